// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU and the LSU.
// One transaction in flight; a stalled WAIT is cut off with an error response.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  input  logic        ls_req_valid,
  input  logic        ls_req_wen,
  input  logic [31:0] ls_req_addr,
  input  logic [31:0] ls_req_wdata,
  input  logic [7:0]  ls_req_wmask,
  input  logic [2:0]  ls_req_rmask,
  output logic        ls_req_ready,
  output logic        ls_resp_valid,
  output logic [31:0] ls_resp_data,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic        m_req_wen,
  output logic [31:0] m_req_addr,
  output logic [31:0] m_req_wdata,
  output logic [7:0]  m_req_wmask,
  output logic [2:0]  m_req_rmask,
  input  logic        m_resp_valid,
  input  logic [31:0] m_resp_data,
  output logic        timeout_err
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  localparam logic        OWN_IF   = 1'b0;
  localparam logic        OWN_LS   = 1'b1;
  localparam logic [2:0]  RMASK_LW = 3'b010;
  localparam logic [7:0]  TO_LIM   = 8'(TIMEOUT_CYC);
  localparam logic [31:0] ERR_DATA = 32'hdeadbeef;

  state_t      state_q, state_d;
  logic        owner_q, owner_d, last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [2:0]  rmask_q, rmask_d;
  logic        if_rv_q, if_rv_d, ls_rv_q, ls_rv_d, to_q, to_d;
  logic [31:0] if_rd_q, if_rd_d, ls_rd_q, ls_rd_d;
  logic        grant_if, grant_ls, resp_hit, to_hit;
  logic [31:0] resp_word;

  // On contention the requester that did not win last time goes first
  assign grant_if = if_req_valid && (!ls_req_valid || last_q == OWN_LS);
  assign grant_ls = ls_req_valid && (!if_req_valid || last_q == OWN_IF);
  // A real response on the limit cycle beats the timeout
  assign resp_hit = (state_q == S_WAIT) && m_resp_valid;
  assign to_hit   = (state_q == S_WAIT) && !m_resp_valid && ((cnt_q + 8'd1) == TO_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_if || grant_ls) state_d = S_REQ;
      S_REQ:   if (m_req_ready)          state_d = S_WAIT;
      S_WAIT:  if (resp_hit || to_hit)   state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if_req_ready = (state_q == S_IDLE) && grant_if;
    ls_req_ready = (state_q == S_IDLE) && grant_ls;
    m_req_valid  = (state_q == S_REQ);
  end

  always_comb begin
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rmask_d   = rmask_q;
    if_rv_d   = 1'b0;
    ls_rv_d   = 1'b0;
    to_d      = 1'b0;
    if_rd_d   = if_rd_q;
    ls_rd_d   = ls_rd_q;
    resp_word = resp_hit ? m_resp_data : ERR_DATA;

    if (state_q == S_IDLE && grant_ls) begin
      owner_d = OWN_LS;
      last_d  = OWN_LS;
      wen_d   = ls_req_wen;
      addr_d  = ls_req_addr;
      wdata_d = ls_req_wdata;
      wmask_d = ls_req_wmask;
      rmask_d = ls_req_rmask;
    end else if (state_q == S_IDLE && grant_if) begin
      owner_d = OWN_IF;
      last_d  = OWN_IF;
      wen_d   = 1'b0;
      addr_d  = if_req_addr;
      wdata_d = 32'd0;
      wmask_d = 8'd0;
      rmask_d = RMASK_LW;
    end

    if (state_q == S_REQ && m_req_ready)
      cnt_d = 8'd0;
    else if (state_q == S_WAIT && !m_resp_valid)
      cnt_d = cnt_q + 8'd1;

    if (resp_hit || to_hit) begin
      to_d = to_hit;
      if (owner_q == OWN_LS) begin
        ls_rv_d = 1'b1;
        ls_rd_d = resp_word;
      end else begin
        if_rv_d = 1'b1;
        if_rd_d = resp_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_IF;
      last_q  <= OWN_LS;
      cnt_q   <= 8'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 8'd0;
      rmask_q <= 3'd0;
      if_rv_q <= 1'b0;
      ls_rv_q <= 1'b0;
      to_q    <= 1'b0;
      if_rd_q <= 32'd0;
      ls_rd_q <= 32'd0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rmask_q <= rmask_d;
      if_rv_q <= if_rv_d;
      ls_rv_q <= ls_rv_d;
      to_q    <= to_d;
      if_rd_q <= if_rd_d;
      ls_rd_q <= ls_rd_d;
    end
  end

  assign m_req_wen     = wen_q;
  assign m_req_addr    = addr_q;
  assign m_req_wdata   = wdata_q;
  assign m_req_wmask   = wmask_q;
  assign m_req_rmask   = rmask_q;
  assign if_resp_valid = if_rv_q;
  assign if_resp_data  = if_rd_q;
  assign ls_resp_valid = ls_rv_q;
  assign ls_resp_data  = ls_rd_q;
  assign timeout_err   = to_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single transactions plus hand-written
// sequences for arbitration, backpressure, timeout and reset, with a response scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready, if_resp_valid;
  logic [31:0] if_req_addr = '0, if_resp_data;
  logic        ls_req_valid = 1'b0, ls_req_wen = 1'b0, ls_req_ready, ls_resp_valid;
  logic [31:0] ls_req_addr = '0, ls_req_wdata = '0, ls_resp_data;
  logic [7:0]  ls_req_wmask = '0;
  logic [2:0]  ls_req_rmask = '0;
  logic        m_req_valid, m_req_ready = 1'b1, m_req_wen, m_resp_valid = 1'b0;
  logic [31:0] m_req_addr, m_req_wdata, m_resp_data = '0;
  logic [7:0]  m_req_wmask;
  logic [2:0]  m_req_rmask;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_wen(ls_req_wen), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_rmask(ls_req_rmask),
    .ls_req_ready(ls_req_ready), .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_wen(m_req_wen),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_req_rmask(m_req_rmask), .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
    .timeout_err(timeout_err)
  );

  int n_chk = 0, n_fail = 0;

  typedef struct { logic ls; logic [31:0] data; logic to; logic chkd; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    logic ls; logic wen; logic [31:0] addr; logic [31:0] wdata; logic [7:0] wmask; logic [2:0] rmask;
    logic [31:0] rdata; int dly; logic x_wen; logic [7:0] x_wmask; logic [2:0] x_rmask;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic ls, input logic [31:0] d, input logic to, input logic chkd);
    exp_t e;
    e.ls = ls; e.data = d; e.to = to; e.chkd = chkd;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for a grant, check who got it, then let the accepting edge pass
  task automatic wait_grant(input logic ls, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (if_req_ready || ls_req_ready) got = 1'b1;
    end
    chk({name, "_grant"}, 32'(got), 32'd1);
    chk({name, "_sel"}, {30'd0, if_req_ready, ls_req_ready}, ls ? 32'd1 : 32'd2);
    tick();
  endtask

  // Entered in REQ with m_req_ready already driven high
  task automatic serve(input logic ls, input logic [31:0] rdata, input int dly, input logic chkd);
    tick();
    repeat (dly) tick();
    m_resp_valid = 1'b1;
    m_resp_data  = rdata;
    push_exp(ls, rdata, 1'b0, chkd);
    tick();
    m_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_req_valid = 1'b0; ls_req_valid = 1'b0; m_resp_valid = 1'b0; m_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst && (if_resp_valid || ls_resp_valid)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {30'd0, if_resp_valid, ls_resp_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_owner", {30'd0, if_resp_valid, ls_resp_valid}, mon_e.ls ? 32'd1 : 32'd2);
        if (mon_e.chkd) chk("resp_data", mon_e.ls ? ls_resp_data : if_resp_data, mon_e.data);
        chk("resp_timeout_err", 32'(timeout_err), 32'(mon_e.to));
      end
    end else if (rst && timeout_err) begin
      chk("stray_timeout", 32'(timeout_err), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b0, 1'b1, 32'h80000004, 32'hffffffff, 8'hff, 3'b111, 32'h00100093, 0, 1'b0, 8'h00, 3'b010};
    vt[1] = '{1'b1, 1'b1, 32'h80001000, 32'hcafef00d, 8'h0f, 3'b000, 32'h0,        1, 1'b1, 8'h0f, 3'b000};
    vt[2] = '{1'b1, 1'b0, 32'h80002000, 32'h0,        8'h00, 3'b100, 32'h12345678, 2, 1'b0, 8'h00, 3'b100};
    vt[3] = '{1'b0, 1'b0, 32'h80000008, 32'h0,        8'h00, 3'b000, 32'hfeedface, 3, 1'b0, 8'h00, 3'b010};

    // Reset values
    @(negedge clk);
    chk("rst_m_req_valid", 32'(m_req_valid), 32'd0);
    chk("rst_if_resp", {if_resp_valid, if_resp_data[30:0]}, 32'd0);
    chk("rst_ls_resp", {ls_resp_valid, ls_resp_data[30:0]}, 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_m_req_addr", m_req_addr, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // IFU-only read, cycle-exact latency
    if_req_addr = 32'h80000000; if_req_valid = 1'b1; m_req_ready = 1'b1;
    @(negedge clk);
    chk("ifu_rd_ready", {30'd0, if_req_ready, ls_req_ready}, 32'd2);
    tick(); if_req_valid = 1'b0;
    @(negedge clk);
    chk("ifu_rd_mvalid", 32'(m_req_valid), 32'd1);
    chk("ifu_rd_maddr", m_req_addr, 32'h80000000);
    tick(); m_resp_valid = 1'b1; m_resp_data = 32'h00000413;
    push_exp(1'b0, 32'h00000413, 1'b0, 1'b1);
    @(negedge clk);
    chk("ifu_rd_early", {30'd0, if_resp_valid, ls_resp_valid}, 32'd0);
    tick(); m_resp_valid = 1'b0;
    @(negedge clk);
    chk("ifu_rd_resp", {30'd0, if_resp_valid, ls_resp_valid}, 32'd2);
    chk("ifu_rd_data", if_resp_data, 32'h00000413);
    tick();
    @(negedge clk);
    chk("ifu_rd_pulse_end", 32'(if_resp_valid), 32'd0);

    // Contention straight after reset: IFU, LSU, IFU
    do_reset();
    if_req_addr = 32'h80000100; ls_req_addr = 32'h80003000;
    ls_req_wen = 1'b0; ls_req_rmask = 3'b010; ls_req_wmask = 8'h00;
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    wait_grant(1'b0, "cont1");
    @(negedge clk);
    chk("cont1_busy_ready", {30'd0, if_req_ready, ls_req_ready}, 32'd0);
    chk("cont1_addr", m_req_addr, 32'h80000100);
    serve(1'b0, 32'h11111111, 0, 1'b1);
    wait_grant(1'b1, "cont2");
    @(negedge clk);
    chk("cont2_busy_ready", {30'd0, if_req_ready, ls_req_ready}, 32'd0);
    chk("cont2_addr", m_req_addr, 32'h80003000);
    serve(1'b1, 32'h22222222, 0, 1'b1);
    wait_grant(1'b0, "cont3");
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    @(negedge clk);
    chk("cont3_addr", m_req_addr, 32'h80000100);
    serve(1'b0, 32'h33333333, 0, 1'b1);

    // Vector table of single transactions
    for (int k = 0; k < 4; k++) begin
      if_req_addr  = vt[k].ls ? ~vt[k].addr : vt[k].addr;
      ls_req_addr  = vt[k].ls ? vt[k].addr : ~vt[k].addr;
      ls_req_wen   = vt[k].wen;
      ls_req_wdata = vt[k].wdata;
      ls_req_wmask = vt[k].wmask;
      ls_req_rmask = vt[k].rmask;
      if_req_valid = !vt[k].ls;
      ls_req_valid = vt[k].ls;
      wait_grant(vt[k].ls, "vec");
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      @(negedge clk);
      chk("vec_mvalid", 32'(m_req_valid), 32'd1);
      chk("vec_addr", m_req_addr, vt[k].addr);
      chk("vec_wen", 32'(m_req_wen), 32'(vt[k].x_wen));
      chk("vec_wmask", 32'(m_req_wmask), 32'(vt[k].x_wmask));
      chk("vec_rmask", 32'(m_req_rmask), 32'(vt[k].x_rmask));
      if (vt[k].x_wen) chk("vec_wdata", m_req_wdata, vt[k].wdata);
      serve(vt[k].ls, vt[k].rdata, vt[k].dly, !vt[k].x_wen);
    end

    // Backpressure: m_req_ready low for 5 cycles, request held stable for 6
    ls_req_addr = 32'h80004000; ls_req_wen = 1'b1; ls_req_wdata = 32'ha5a55a5a;
    ls_req_wmask = 8'hf0; ls_req_rmask = 3'b000; m_req_ready = 1'b0;
    ls_req_valid = 1'b1;
    wait_grant(1'b1, "bp");
    if_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) m_req_ready = 1'b1;
      @(negedge clk);
      chk("bp_mvalid", 32'(m_req_valid), 32'd1);
      chk("bp_addr", m_req_addr, 32'h80004000);
      chk("bp_wdata", m_req_wdata, 32'ha5a55a5a);
      chk("bp_wmask_wen", {23'd0, m_req_wen, m_req_wmask}, {23'd0, 1'b1, 8'hf0});
      chk("bp_readies", {30'd0, if_req_ready, ls_req_ready}, 32'd0);
      if (i < 5) tick();
    end
    serve(1'b1, 32'h0, 1, 1'b0);
    if_req_valid = 1'b0; ls_req_valid = 1'b0;

    // Timeout with no response, then a response on the limit cycle
    ls_req_addr = 32'h80005000; ls_req_wen = 1'b0; ls_req_rmask = 3'b100; ls_req_wmask = 8'h00;
    ls_req_valid = 1'b1;
    wait_grant(1'b1, "to");
    ls_req_valid = 1'b0;
    tick();
    push_exp(1'b1, 32'hdeadbeef, 1'b1, 1'b1);
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge clk);
      chk("to_early", {30'd0, timeout_err, ls_resp_valid}, 32'd0);
      tick();
    end
    ls_req_addr = 32'h80005004; ls_req_valid = 1'b1;
    @(negedge clk);
    chk("to_pulse", 32'(timeout_err), 32'd1);
    chk("to_ls_resp", {30'd0, if_resp_valid, ls_resp_valid}, 32'd1);
    chk("to_data", ls_resp_data, 32'hdeadbeef);
    chk("to_idle_ready", 32'(ls_req_ready), 32'd1);
    tick();
    ls_req_valid = 1'b0;
    @(negedge clk);
    chk("to_pulse_end", 32'(timeout_err), 32'd0);
    chk("to_next_mvalid", 32'(m_req_valid), 32'd1);
    serve(1'b1, 32'h0badf00d, int'(TO) - 1, 1'b1);

    // Reset in WAIT aborts silently; a late response is dropped
    ls_req_addr = 32'h80006000; ls_req_valid = 1'b1;
    wait_grant(1'b1, "rw");
    ls_req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rw_m_req_valid", 32'(m_req_valid), 32'd0);
    chk("rw_resp_valid", {30'd0, if_resp_valid, ls_resp_valid}, 32'd0);
    chk("rw_if_data", if_resp_data, 32'd0);
    chk("rw_ls_data", ls_resp_data, 32'd0);
    chk("rw_timeout", 32'(timeout_err), 32'd0);
    chk("rw_m_req_addr", m_req_addr, 32'd0);
    chk("rw_m_req_rmask", 32'(m_req_rmask), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    m_resp_valid = 1'b1; m_resp_data = 32'h55aa55aa;
    tick();
    m_resp_valid = 1'b0;
    @(negedge clk);
    chk("rw_late_resp", {30'd0, if_resp_valid, ls_resp_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("rw_idle", 32'(m_req_valid), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum number of cycles spent in WAIT before the block forces an error response (range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have IFU ports: if_req_valid in 1; if_req_addr in 32; if_req_ready out 1; if_resp_valid out 1; if_resp_data out 32.
REQ-005 The block SHALL have LSU ports: ls_req_valid in 1; ls_req_wen in 1; ls_req_addr in 32; ls_req_wdata in 32; ls_req_wmask in 8; ls_req_rmask in 3; ls_req_ready out 1; ls_resp_valid out 1; ls_resp_data out 32.
REQ-006 The block SHALL have memory-side ports: m_req_valid out 1; m_req_ready in 1; m_req_wen out 1; m_req_addr out 32; m_req_wdata out 32; m_req_wmask out 8; m_req_rmask out 3; m_resp_valid in 1; m_resp_data in 32.
REQ-007 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a transaction times out.

Function
REQ-008 The block SHALL implement the FSM states IDLE, REQ and WAIT, with exactly one transaction outstanding at any time.
REQ-009 In IDLE, if_req_ready and ls_req_ready SHALL be combinational, and at most one of them SHALL be high, and only for the selected requester whose valid is high.
REQ-010 Selection SHALL be round-robin: if only one requester is valid, that requester wins; if both are valid, the requester other than last_owner wins.
REQ-011 On an accepted handshake (valid && ready), the block SHALL latch the address, wen, wdata, wmask and rmask (IFU: wen=0, wmask=0, rmask=LoadW encoding), set owner and last_owner, and go to REQ.
REQ-012 In REQ, m_req_valid SHALL be 1 and the m_req_* fields SHALL be the latched values, held stable until m_req_ready=1; on that cycle the FSM SHALL go to WAIT.
REQ-013 Outside REQ, m_req_valid SHALL be 0.
REQ-014 In WAIT, on m_resp_valid=1 the block SHALL register m_resp_data into the owner's resp_data and pulse the owner's resp_valid for exactly one cycle, in the following cycle, and go to IDLE in that same edge.
REQ-015 The non-owner's resp_valid SHALL stay 0.
REQ-016 Minimum latency SHALL be: accept in cycle N; m_req_valid in N+1; with m_req_ready=1 in N+1 and m_resp_valid=1 in N+2, resp_valid is asserted in N+3.
REQ-017 An LSU write SHALL also wait for m_resp_valid as its acknowledge; ls_resp_data is don't-care for writes.
REQ-018 An 8-bit wait counter SHALL clear on entry to WAIT and increment each cycle in WAIT without m_resp_valid.
REQ-019 When the wait counter reaches TIMEOUT_CYC, the block SHALL pulse timeout_err and the owner's resp_valid for one cycle, with resp_data=32'hdeadbeef, and go to IDLE.
REQ-020 If m_resp_valid arrives in the same cycle the counter would reach TIMEOUT_CYC, the block SHALL treat it as a normal response with no error.
REQ-021 m_resp_valid received in IDLE or REQ SHALL be ignored.
REQ-022 Requests arriving while the FSM is not in IDLE SHALL see ready=0 and SHALL NOT be lost, because the requester holds valid.
REQ-023 New acceptance in IDLE MAY occur on the same cycle that resp_valid is high.

Reset
REQ-024 When rst=0, the block SHALL go to IDLE immediately, regardless of clk.
REQ-025 During reset, the block SHALL set the wait counter to 0, owner to IFU, last_owner to LSU, all resp_valid outputs to 0, all resp_data outputs to 0, m_req_valid to 0, timeout_err to 0, and all latched request fields to 0.
REQ-026 Reset asserted mid-transaction SHALL abort the transaction with no response issued.
REQ-027 After reset is released, the first contended arbitration SHALL grant the IFU.

Verification
REQ-028 The bench SHALL cover the IFU-only read: if addr=0x80000000, m_req_ready=1, m_resp_data=0x00000413 one cycle later -> if_resp_valid pulse with data 0x00000413 at N+3; ls_resp_valid stays 0.
REQ-029 The bench SHALL cover contention after reset: both valid in the same cycle -> IFU granted first, LSU granted in the next IDLE, then IFU again if both are still valid.
REQ-030 The bench SHALL cover an LSU write: addr 0x80001000, wdata 0xcafef00d, wmask 0x0f -> m_req_* carry these exact values; ls_resp_valid pulses after the ack; no IFU response.
REQ-031 The bench SHALL cover backpressure: m_req_ready held at 0 for 5 cycles -> m_req_valid and fields stable for 6 cycles; both readies 0 throughout.
REQ-032 The bench SHALL cover timeout: TIMEOUT_CYC=4, no m_resp_valid -> timeout_err pulse and ls_resp_data=0xdeadbeef, FSM back in IDLE; then check m_resp_valid arriving on the boundary cycle -> normal response, no error.
REQ-033 The bench SHALL cover reset in WAIT: rst low for 2 cycles -> all outputs reach their reset values asynchronously; a late m_resp_valid after release produces no response.
